// File: rtl/key_sequence_tx_if.sv
// key_sequence_tx_if -- control and serial-output bundle for key_sequence_tx.
//
// Ports (as signals of the interface):
//   start     : request one key transmission
//   abort     : cancel the transmission in progress
//   key_load  : write key_in into the key register
//   key_in    : new key value (KEY_LEN bits)
//   tx_bit    : serial key bit, MSB first
//   tx_valid  : tx_bit carries a key bit this cycle
//   busy      : transmission or guard gap in progress
//   done      : one-cycle pulse on normal completion
//   aborted   : one-cycle pulse on cancelled transmission
//   err       : one-cycle pulse when a start is rejected
// Modports: master drives the requests, slave is the transmitter.
interface key_sequence_tx_if #(
  parameter int KEY_LEN = 11
);
  logic               start;
  logic               abort;
  logic               key_load;
  logic [KEY_LEN-1:0] key_in;
  logic               tx_bit;
  logic               tx_valid;
  logic               busy;
  logic               done;
  logic               aborted;
  logic               err;

  modport master (
    output start, abort, key_load, key_in,
    input  tx_bit, tx_valid, busy, done, aborted, err
  );

  modport slave (
    input  start, abort, key_load, key_in,
    output tx_bit, tx_valid, busy, done, aborted, err
  );
endinterface

// File: rtl/key_sequence_tx.sv
// key_sequence_tx -- serial key transmitter.
//
// Sends the stored KEY_LEN-bit key MSB first, one bit per cycle, followed by
// GAP_CYCLES guard cycles and a one-cycle completion state. A key holding two
// adjacent 1 bits is rejected at start with a one-cycle err pulse. The key
// register can only be rewritten while idle.
//
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : key_sequence_tx_if.slave (start/abort/key_load/key_in in,
//         tx_bit/tx_valid/busy/done/aborted/err out)
module key_sequence_tx #(
  parameter int                 KEY_LEN    = 11,
  parameter logic [KEY_LEN-1:0] KEY_INIT   = 11'b00010010100,
  parameter int                 GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  key_sequence_tx_if.slave  bus
);

  localparam int                 CNT_W    = $clog2(KEY_LEN);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(KEY_LEN - 1);
  localparam logic [3:0]         GAP_LOAD = 4'(GAP_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [KEY_LEN-1:0] key_reg;
  logic [KEY_LEN-1:0] shreg;
  logic [CNT_W-1:0]   bit_cnt;
  logic [3:0]         gap_cnt;
  logic               err_r;
  logic               aborted_r;

  logic               key_ok;
  logic               load_key;
  logic               enter_send;
  logic               enter_gap;
  logic               err_nxt;
  logic               abort_nxt;

  // A key is usable only if no two neighbouring bits are both 1.
  function automatic logic key_valid(input logic [KEY_LEN-1:0] k);
    return (k & (k >> 1)) == '0;
  endfunction

  assign key_ok = key_valid(key_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_key   = 1'b0;
    enter_send = 1'b0;
    enter_gap  = 1'b0;
    err_nxt    = 1'b0;
    abort_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // key_load wins over start; abort has no meaning here.
        if (bus.key_load) begin
          load_key = 1'b1;
        end else if (bus.start) begin
          if (key_ok) begin
            state_nxt  = SEND;
            enter_send = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      SEND: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          abort_nxt = 1'b1;
        end else if (bit_cnt == '0) begin
          state_nxt = GAP;
          enter_gap = 1'b1;
        end
      end
      GAP: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          abort_nxt = 1'b1;
        end else if (gap_cnt <= 4'd1) begin
          state_nxt = FIN;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_reg   <= KEY_INIT;
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      err_r     <= 1'b0;
      aborted_r <= 1'b0;
    end else begin
      // Status pulses are registered so they appear for exactly the cycle
      // after the decision, while the FSM is already back in IDLE.
      err_r     <= err_nxt;
      aborted_r <= abort_nxt;

      if (load_key) key_reg <= bus.key_in;

      if (enter_send) begin
        shreg   <= key_reg;
        bit_cnt <= CNT_LAST;
      end else if (state == SEND) begin
        shreg <= shreg << 1;
        // Counter saturates at zero; it is only reloaded on entry to SEND.
        if (bit_cnt != '0) bit_cnt <= bit_cnt - CNT_W'(1);
      end

      if (enter_gap) begin
        gap_cnt <= GAP_LOAD;
      end else if (state == GAP && gap_cnt != 4'd0) begin
        gap_cnt <= gap_cnt - 4'd1;
      end
    end
  end

  assign bus.tx_valid = (state == SEND);
  assign bus.tx_bit   = (state == SEND) & shreg[KEY_LEN-1];
  assign bus.busy     = (state == SEND) || (state == GAP);
  assign bus.done     = (state == FIN);
  assign bus.aborted  = aborted_r;
  assign bus.err      = err_r;

endmodule

// File: tb/tb_key_sequence_tx.sv
// Testbench for key_sequence_tx: a table of directed vectors, hand-written
// corner sequences and a randomized run checked against a timeline model.
// The model keeps a queue of per-cycle expected outputs: an accepted start
// appends the whole transmission (key bits, guard gap, completion cycle).
module tb_key_sequence_tx;
  localparam int KL  = 11;
  localparam int GAP = 4;
  localparam logic [KL-1:0] KINIT = 11'b00010010100;

  // Output vector layout: {tx_bit, tx_valid, busy, done, aborted, err}
  typedef logic [5:0] out_t;

  typedef struct {
    logic          start;
    logic          abort;
    logic          key_load;
    logic [KL-1:0] key_in;
    out_t          exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_sequence_tx_if #(.KEY_LEN(KL)) bus();

  key_sequence_tx #(
    .KEY_LEN(KL),
    .KEY_INIT(KINIT),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [KL-1:0] mkey;
  out_t          mq[$];
  out_t          act;
  out_t          mexp;
  vec_t          tbl[$];

  function automatic out_t outs();
    return {bus.tx_bit, bus.tx_valid, bus.busy, bus.done, bus.aborted, bus.err};
  endfunction

  task automatic chk(input string name, input out_t a, input out_t e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %b, wanted %b ({tx_bit,tx_valid,busy,done,aborted,err}) at %0t",
               name, a, e, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mkey = KINIT;
  endtask

  task automatic push_tx(input logic [KL-1:0] k);
    for (int i = KL - 1; i >= 0; i--) mq.push_back({k[i], 1'b1, 1'b1, 3'b000});
    for (int i = 0; i < GAP; i++)     mq.push_back(6'b001000);
    mq.push_back(6'b000100);
  endtask

  // One clock cycle: drive inputs, sample outputs, advance the model.
  task automatic cyc(input logic s, input logic a, input logic l, input logic [KL-1:0] k);
    logic idle;
    @(negedge clk);
    bus.start    = s;
    bus.abort    = a;
    bus.key_load = l;
    bus.key_in   = k;
    #1;
    act  = outs();
    mexp = (mq.size() != 0) ? mq[0] : 6'b000000;
    idle = !mexp[3] && !mexp[2];
    if (mq.size() != 0) void'(mq.pop_front());
    if (idle) begin
      if (l) mkey = k;
      else if (s) begin
        if ((mkey & (mkey >> 1)) == '0) push_tx(mkey);
        else mq.push_back(6'b000001);
      end
    end else if (mexp[3] && a) begin
      mq.delete();
      mq.push_back(6'b000010);
    end
  endtask

  task automatic run(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, 1'b0, '0);
      chk(name, act, mexp);
    end
  endtask

  task automatic addv(input logic s, input logic a, input logic l,
                      input logic [KL-1:0] k, input out_t e);
    vec_t v;
    v.start = s; v.abort = a; v.key_load = l; v.key_in = k; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic pulse_reset(input string name);
    @(negedge clk);
    rst = 1'b1;
    #1 chk({name, "_async"}, outs(), 6'b000000);
    @(negedge clk);
    #1 chk({name, "_held"}, outs(), 6'b000000);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [KL-1:0] dk;
    logic [KL-1:0] alt;
    logic [KL-1:0] r;

    dk  = KINIT;
    alt = 11'b10101010101;

    // Default-key transmission right after reset.
    addv(1'b1, 1'b0, 1'b0, '0, 6'b000000);
    for (int i = 0; i < KL; i++) addv(1'b0, 1'b0, 1'b0, '0, {dk[KL-1-i], 5'b11000});
    for (int i = 0; i < GAP; i++) addv(1'b0, 1'b0, 1'b0, '0, 6'b001000);
    addv(1'b0, 1'b0, 1'b0, '0, 6'b000100);
    addv(1'b0, 1'b0, 1'b0, '0, 6'b000000);
    // Invalid key: rejected with a single err pulse, no transmission.
    addv(1'b0, 1'b0, 1'b1, 11'b00110000000, 6'b000000);
    addv(1'b1, 1'b0, 1'b0, '0, 6'b000000);
    addv(1'b0, 1'b0, 1'b0, '0, 6'b000001);
    addv(1'b0, 1'b0, 1'b0, '0, 6'b000000);
    addv(1'b0, 1'b1, 1'b0, '0, 6'b000000);   // abort while idle: no effect
    addv(1'b0, 1'b0, 1'b0, '0, 6'b000000);

    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.key_load = 1'b0;
    bus.key_in   = '0;
    model_reset();

    // Outputs while reset is held.
    @(negedge clk);
    #1 chk("reset_outs", outs(), 6'b000000);
    @(negedge clk);
    #1 chk("reset_outs2", outs(), 6'b000000);
    rst = 1'b0;

    foreach (tbl[i]) begin
      cyc(tbl[i].start, tbl[i].abort, tbl[i].key_load, tbl[i].key_in);
      chk($sformatf("table[%0d]", i), act, tbl[i].exp);
    end

    // Alternating key; key_load and start during SEND must be ignored.
    cyc(1'b0, 1'b0, 1'b1, alt);
    chk("alt_load", act, mexp);
    cyc(1'b1, 1'b0, 1'b0, '0);
    chk("alt_start", act, mexp);
    for (int i = 0; i < KL; i++) begin
      if (i == 3) cyc(1'b1, 1'b0, 1'b1, '0);
      else        cyc(1'b0, 1'b0, 1'b0, '0);
      chk($sformatf("alt_bit[%0d]", i), act, {alt[KL-1-i], 5'b11000});
    end
    run(GAP + 2, "alt_tail");
    cyc(1'b1, 1'b0, 1'b0, '0);
    chk("alt_restart", act, mexp);
    cyc(1'b0, 1'b0, 1'b0, '0);
    chk("alt_key_kept", act, 6'b111000);
    run(KL + GAP + 2, "alt_drain");

    // key_load with start in the same idle cycle: load only.
    cyc(1'b1, 1'b0, 1'b1, 11'b01001000100);
    chk("load_start", act, mexp);
    cyc(1'b0, 1'b0, 1'b0, '0);
    chk("load_start_no_tx", act, 6'b000000);
    cyc(1'b1, 1'b0, 1'b0, '0);
    chk("new_key_start", act, mexp);
    run(KL + GAP + 2, "new_key_tx");

    // Abort on the 5th SEND cycle, then immediate restart.
    cyc(1'b1, 1'b0, 1'b0, '0);
    chk("abort_start", act, mexp);
    run(4, "abort_send");
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk("abort_send5", act, mexp);
    cyc(1'b1, 1'b0, 1'b0, '0);
    chk("abort_pulse", act, 6'b000010);
    cyc(1'b0, 1'b0, 1'b0, '0);
    chk("abort_restart", {4'b0000, act[4:3]}, 6'b000011);
    chk("abort_restart_model", act, mexp);
    run(KL + GAP + 2, "abort_drain");

    // Reset during GAP, then the default key goes out again.
    cyc(1'b1, 1'b0, 1'b0, '0);
    chk("gap_rst_start", act, mexp);
    run(KL + 2, "gap_rst_pre");
    chk("gap_rst_in_gap", act, 6'b001000);
    pulse_reset("gap_rst");
    cyc(1'b1, 1'b0, 1'b0, '0);
    chk("post_rst_start", act, 6'b000000);
    for (int i = 0; i < KL; i++) begin
      cyc(1'b0, 1'b0, 1'b0, '0);
      chk($sformatf("post_rst_bit[%0d]", i), act, {dk[KL-1-i], 5'b11000});
    end
    run(GAP + 2, "post_rst_tail");

    // Randomized traffic against the timeline model.
    for (int n = 0; n < 3000; n++) begin
      logic s, a, l;
      r = KL'($urandom);
      if ($urandom_range(0, 1) == 1) r = r & ~(r << 1);
      s = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 15) == 0);
      l = ($urandom_range(0, 9) == 0);
      cyc(s, a, l, r);
      chk("random", act, mexp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
